fb_rect_filler: RTL and testbench

//  Rectangle-fill engine upstream of the VGA framebuffer. Accepts one command (x, y, w, h, colour).

---
 rtl/fb_pkg.sv | 42 ++++
 rtl/fb_rect_filler.sv | 117 +++++++++++
 tb/tb_fb_rect_filler.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: playfield geometry, palette indices and the write-word format.
// The fill engine and the framebuffer decoder both import this package.
package fb_pkg;

  localparam int unsigned FB_W       = 150;
  localparam int unsigned FB_H       = 480;
  localparam int unsigned ROW_STRIDE = 256;

  typedef logic [16:0] fb_addr_t;

  typedef enum logic [5:0] {
    BLACK       = 6'd0,
    WHITE       = 6'd1,
    RED         = 6'd2,
    GREEN       = 6'd3,
    BLUE        = 6'd4,
    YELLOW      = 6'd5,
    CYAN        = 6'd6,
    MAGENTA     = 6'd7,
    ORANGE      = 6'd8,
    PURPLE      = 6'd9,
    PINK        = 6'd10,
    GREY        = 6'd11,
    DARK_GREY   = 6'd12,
    LIGHT_BLUE  = 6'd13,
    DARK_BLUE   = 6'd14,
    DARK_GREEN  = 6'd15,
    LIGHT_GREEN = 6'd16,
    DARK_RED    = 6'd17,
    BROWN       = 6'd18,
    DARK_ORANGE = 6'd19
  } colour_t;

  // Row stride is a power of two, so the address is just {y, x}.
  function automatic logic [31:0] fb_pack(input logic [7:0] x, input logic [8:0] y,
                                          input logic [5:0] c);
    fb_addr_t addr;
    addr = {y, x};
    return {9'b0, addr, c};
  endfunction

endpackage

// File: rtl/fb_rect_filler.sv
// Rectangle fill engine: takes one (x, y, w, h, colour) command and streams clipped
// framebuffer writes, one pixel per unstalled cycle, in row-major order.
module fb_rect_filler
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [7:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [5:0]  cmd_color,
  input  logic        fb_stall,
  output logic        fb_chipselect,
  output logic        fb_write,
  output logic [31:0] fb_writedata,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [8:0] X_LIM = 9'(FB_W);
  localparam logic [9:0] Y_LIM = 10'(FB_H);

  state_t      state, state_next;
  logic [7:0]  x0, w_q, cx;
  logic [8:0]  y0, h_q, cy;
  logic [5:0]  col;
  logic [8:0]  x_end, x_sum, x_clip;
  logic [9:0]  y_end, y_sum, y_clip;
  logic        empty, row_last, col_last;

  // Sums are one bit wider than the operands so a far-right/bottom rectangle never wraps.
  always_comb begin
    x_sum  = {1'b0, x0} + {1'b0, w_q};
    y_sum  = {1'b0, y0} + {1'b0, h_q};
    x_clip = (x_sum > X_LIM) ? X_LIM : x_sum;
    y_clip = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    empty  = ({1'b0, x0} >= x_clip) || ({1'b0, y0} >= y_clip);
  end

  assign col_last = ({1'b0, cx} == (x_end - 9'd1));
  assign row_last = ({1'b0, cy} == (y_end - 10'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (cmd_valid) state_next = SETUP;
      SETUP: state_next = empty ? DONE : FILL;
      FILL:  if (!fb_stall && col_last && row_last) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0           <= '0;
      y0           <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col          <= '0;
      x_end        <= '0;
      y_end        <= '0;
      cx           <= '0;
      cy           <= '0;
      fb_write     <= 1'b0;
      fb_writedata <= '0;
      done         <= 1'b0;
    end else begin
      fb_write <= (state == FILL) && !fb_stall;
      done     <= (state == DONE);
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x0  <= cmd_x;
            y0  <= cmd_y;
            w_q <= cmd_w;
            h_q <= cmd_h;
            col <= cmd_color;
          end
        end
        SETUP: begin
          x_end <= x_clip;
          y_end <= y_clip;
          cx    <= x0;
          cy    <= y0;
        end
        FILL: begin
          if (!fb_stall) begin
            fb_writedata <= fb_pack(cx, cy, col);
            if (col_last) begin
              cx <= x0;
              cy <= cy + 9'd1;
            end else begin
              cx <= cx + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign fb_chipselect = fb_write;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Directed bench for fb_rect_filler: a table of commands with hand-computed write counts and
// first words, a small address-order model, plus a hand-written reset-during-fill sequence.
module tb_fb_rect_filler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [5:0]  cmd_color;
  logic        fb_stall;
  logic        fb_chipselect;
  logic        fb_write;
  logic [31:0] fb_writedata;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_rect_filler dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .fb_stall     (fb_stall),
    .fb_chipselect(fb_chipselect),
    .fb_write     (fb_write),
    .fb_writedata (fb_writedata),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    string       name;
    logic [7:0]  x;
    logic [8:0]  y;
    logic [7:0]  w;
    logic [8:0]  h;
    logic [5:0]  c;
    int          n;
    logic [31:0] first;
    int          stall_after;
    int          stall_len;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(string name, logic [7:0] x, logic [8:0] y, logic [7:0] w,
                              logic [8:0] h, logic [5:0] c, int n, logic [31:0] first,
                              int stall_after, int stall_len);
    vec_t v;
    v.name = name; v.x = x; v.y = y; v.w = w; v.h = h; v.c = c;
    v.n = n; v.first = first; v.stall_after = stall_after; v.stall_len = stall_len;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int xe, ye, ex, ey, nwr, ndone, first_j, done_j, ord_err, leak, cs_err, stall_left, limit;
    logic [31:0] first_word, exp_word;
    logic ready_at_done, busy_at_done, ready_in_done;
    xe = int'(v.x) + int'(v.w); if (xe > 150) xe = 150;
    ye = int'(v.y) + int'(v.h); if (ye > 480) ye = 480;
    ex = int'(v.x); ey = int'(v.y);
    nwr = 0; ndone = 0; first_j = -1; done_j = -1; ord_err = 0; leak = 0; cs_err = 0;
    stall_left = v.stall_len; first_word = '0;
    ready_at_done = 1'b0; busy_at_done = 1'b1; ready_in_done = 1'b1;
    limit = v.n + v.stall_len + 6;

    @(negedge clk);
    check({v.name, " ready_before_cmd"}, 32'(cmd_ready), 32'd1);
    cmd_x = v.x; cmd_y = v.y; cmd_w = v.w; cmd_h = v.h; cmd_color = v.c;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int j = 0; j < limit; j++) begin
      @(negedge clk);
      if (j == 0) begin
        // Fields change while busy; the engine must keep the latched command.
        cmd_valid = 1'b0;
        cmd_x = 8'($urandom); cmd_y = 9'($urandom); cmd_w = 8'($urandom);
        cmd_h = 9'($urandom); cmd_color = 6'($urandom);
      end
      if (fb_chipselect !== fb_write) cs_err++;
      if (fb_write === 1'b1) begin
        if (fb_stall) leak++;
        if (nwr == 0) begin
          first_j = j;
          first_word = fb_writedata;
        end
        exp_word = {9'b0, 9'(ey), 8'(ex), v.c};
        if (nwr >= v.n || fb_writedata !== exp_word) ord_err++;
        if (ex + 1 >= xe) begin ex = int'(v.x); ey++; end
        else ex++;
        nwr++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_j < 0) begin
          done_j = j;
          ready_at_done = cmd_ready;
          busy_at_done = busy;
        end
      end
      if (j == v.n + v.stall_len + 1) ready_in_done = cmd_ready;
      if (nwr == v.stall_after && stall_left > 0) begin
        fb_stall = 1'b1;
        stall_left--;
      end else begin
        fb_stall = 1'b0;
      end
    end
    fb_stall = 1'b0;

    check({v.name, " write_count"}, 32'(nwr), 32'(v.n));
    check({v.name, " order_errors"}, 32'(ord_err), 32'd0);
    check({v.name, " chipselect_errors"}, 32'(cs_err), 32'd0);
    check({v.name, " done_cycle"}, 32'(done_j), 32'(v.n + v.stall_len + 2));
    check({v.name, " done_pulses"}, 32'(ndone), 32'd1);
    check({v.name, " ready_low_in_done"}, 32'(ready_in_done), 32'd0);
    check({v.name, " ready_after_done"}, 32'(ready_at_done), 32'd1);
    check({v.name, " busy_after_done"}, 32'(busy_at_done), 32'd0);
    if (v.n > 0) begin
      check({v.name, " first_word"}, first_word, v.first);
      check({v.name, " first_latency"}, 32'(first_j), 32'd2);
    end
    if (v.stall_len > 0) check({v.name, " stall_leaks"}, 32'(leak), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk("1x1_origin", 8'd0,   9'd0,   8'd1,  9'd1, 6'd2, 1, 32'h0000_0002, 0, 0);
    vecs[1] = mk("3x2_at_10_5",8'd10,  9'd5,   8'd3,  9'd2, 6'd5, 6, 32'h0001_4285, 0, 0);
    vecs[2] = mk("clip_corner",8'd148, 9'd479, 8'd10, 9'd5, 6'd3, 2, 32'h0077_E503, 0, 0);
    vecs[3] = mk("empty_w0",   8'd5,   9'd5,   8'd0,  9'd4, 6'd1, 0, 32'h0,         0, 0);
    vecs[4] = mk("empty_x150", 8'd150, 9'd0,   8'd4,  9'd1, 6'd1, 0, 32'h0,         0, 0);
    vecs[5] = mk("stall_4x1",  8'd20,  9'd3,   8'd4,  9'd1, 6'd7, 4, 32'h0000_C507, 2, 3);
    vecs[6] = mk("empty_h0",   8'd1,   9'd1,   8'd3,  9'd0, 6'd4, 0, 32'h0,         0, 0);
    vecs[7] = mk("empty_y480", 8'd0,   9'd480, 8'd1,  9'd1, 6'd4, 0, 32'h0,         0, 0);

    reset = 1'b1; cmd_valid = 1'b0; fb_stall = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset fb_write", 32'(fb_write), 32'd0);
    check("reset writedata", fb_writedata, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a full-screen clear.
    @(negedge clk);
    cmd_x = 8'd0; cmd_y = 9'd0; cmd_w = 8'd150; cmd_h = 9'd480; cmd_color = 6'd1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("midfill fb_write", 32'(fb_write), 32'd1);
    check("midfill busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset fb_write", 32'(fb_write), 32'd0);
    check("async_reset chipselect", 32'(fb_chipselect), 32'd0);
    check("async_reset writedata", fb_writedata, 32'd0);
    check("async_reset busy", 32'(busy), 32'd0);
    check("async_reset done", 32'(done), 32'd0);
    check("async_reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
